tx_arbiter: RTL
===============

# tx_arbiter

Sequencing controller and arbiter for the serial transmit path. Shares one `transmit` instance between `N_REQ` byte-producing requesters: it selects a requester, captures its byte, drives the transmitter's `load` / `transmitEnable` handshake, and waits for `charSent`. It then releases the transmitter, signals completion to the requester, and enforces an inter-character gap. It sits directly between the requester logic and the `transmit` block, on the same 16x clock.

## Interface
- `N_REQ`, 4 — number of requesters, 2..8.
- `GAP_CYCLES`, 16 — idle clocks between the release of one character and the next arbitration, 1..255.

- `clk` in 1 — 16x bit clock, shared with `transmit`.
- `rst` in 1 — asynchronous, active-low reset.
- `req` in `N_REQ` — per-requester send request; level, held until `done`.
- `reqData` in `N_REQ*8` — byte for requester i at `[8i+7:8i]`; must be stable while `req[i]` is high.
- `grant` out `N_REQ` — one-hot owner of the transmitter.
- `done` out `N_REQ` — one-cycle pulse; the owner's character is fully sent.
- `busy` out 1 — high in every state except IDLE.
- `load` out 1 — to `transmit.load`.
- `parallelDataIn` out 8 — to `transmit.parallelDataIn`; captured byte.
- `transmitEnable` out 1 — to `transmit.transmitEnable`.
- `charSent` in 1 — from `transmit.charSent`.

## Operation
- **FSM states:** IDLE, LOAD, SEND, RELEASE, GAP. All outputs are registered.
- **IDLE**
  - `grant`, `load`, `transmitEnable`, `busy` = 0.
  - If `|req`, pick a winner, capture its byte into the data register and its index into the owner register, then go to LOAD.
- **LOAD** (exactly 1 cycle)
  - `load` = 1, `transmitEnable` = 1, `grant[owner]` = 1.
  - Next state: SEND.
- **SEND**
  - `transmitEnable` = 1, `load` = 0, `grant` held.
  - Leave for RELEASE on the first cycle `charSent` = 1.
- **RELEASE**
  - `transmitEnable` = 0; this triggers the transmitter's auto-reset.
  - `done[owner]` pulses in the first RELEASE cycle only.
  - Stay until `charSent` = 0, then drop `grant` and go to GAP.
- **GAP**
  - An 8-bit counter loads `GAP_CYCLES-1` on entry and decrements.
  - At 0, go to IDLE.
  - `req` is ignored here, so a requester has at least `GAP_CYCLES` clocks after `done` to drop or renew `req`.
- **Request drop:** deassertion of `req[owner]` after capture is ignored. The character completes and `done` still pulses.
- **New requests:** requests arriving in LOAD, SEND, RELEASE or GAP wait for IDLE; none are lost while `req` is held.
- **Arbitration:** see Configuration. The winner is always a requester with `req` = 1 in the IDLE cycle.
- **`parallelDataIn`:** driven from the data register at all times, so it stays stable for the whole transmission.

## Timing
- **Reset:**
  - State IDLE.
  - `grant`, `done`, `busy`, `load`, `transmitEnable` = 0.
  - `parallelDataIn` = 8'h00, gap counter = 0, round-robin pointer = 0.
- **Reset mid-transmission** (any state): outputs return to reset values asynchronously. The transmitter sees `transmitEnable` fall; no `done` is issued.
- **Start latency:** `req` sampled high in IDLE at edge t → `load` and `transmitEnable` high after edge t+1.
- **Completion:** `charSent` high sampled at edge c → `transmitEnable` low and `done` high after c+1.
- **Back-to-back turnaround:** from `charSent` rise to the next `load` is `GAP_CYCLES` + 3 clocks minimum (1 SEND→RELEASE, ≥1 RELEASE, `GAP_CYCLES` GAP, 1 IDLE).
- **Simultaneous `req` and grant decision:** resolved in the IDLE cycle only. If `charSent` is already 1 on entry to SEND, SEND lasts 1 cycle.

## Configuration
- **`TX_ARB_ROUND_ROBIN_EN` defined:**
  - Round-robin arbitration. The search starts at the pointer and wraps modulo `N_REQ`.
  - On each grant, the pointer becomes owner+1, wrapping to 0 after `N_REQ-1`.
- **Not defined:**
  - Fixed priority; the lowest requesting index wins.
  - No pointer register exists.

## Test plan
- **Reset and single send:** reset; `req` = 4'b0010, byte 8'hAA → `grant` = 4'b0010. `load` is high for 1 cycle at IDLE+1 and `parallelDataIn` = 8'hAA. `done` = 4'b0010 pulses once after `charSent`. `busy` is low `GAP_CYCLES`+2 clocks after `charSent` falls.
- **Contention, `TX_ARB_ROUND_ROBIN_EN`:** `req` = 4'b1111 held, bytes 8'h11/22/33/44 → grant order 0,1,2,3,0. The serial output carries 11,22,33,44.
- **Contention, macro undefined:** `req` = 4'b1010 held → requester 1 is granted repeatedly and requester 3 never is. Drop `req[1]` during GAP → requester 3 is granted next.
- **Request dropped in SEND:** the character still completes and `done[owner]` pulses; no other requester is granted until GAP ends.
- **Reset mid-SEND:** assert `rst` = 0 → `transmitEnable`, `grant`, `busy` = 0 immediately, no `done`. After release, a fresh `req` transmits correctly.
- **`GAP_CYCLES` = 1, continuous single requester:** successive `load` pulses are spaced exactly one full character plus 4 clocks apart; `charSent` is observed low before each `load`.

Source files
------------

// File: rtl/tx_arbiter.sv
// tx_arbiter: shares one serial transmitter among N_REQ byte requesters; all outputs registered.
// Define TX_ARB_ROUND_ROBIN_EN for round-robin arbitration; default build is fixed priority.
module tx_arbiter #(
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [N_REQ*8-1:0] reqData_i,
  output logic [N_REQ-1:0]   grant_o,
  output logic [N_REQ-1:0]   done_o,
  output logic               busy_o,
  output logic               load_o,
  output logic [7:0]         parallelDataIn_o,
  output logic               transmitEnable_o,
  input  logic               charSent_i
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_RELEASE, S_GAP} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       gap_q, gap_d;
  logic             rel_first_q, rel_first_d;
  logic [N_REQ-1:0] grant_q, grant_d, done_q, done_d, own_oh;
  logic             busy_q, busy_d, load_q, load_d, te_q, te_d;
  logic             win_vld;
  logic [IW-1:0]    win_idx;

  assign own_oh = N_REQ'(1) << owner_q;

`ifdef TX_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q, ptr_d;

  // Scan downwards so the last hit is the requester nearest the pointer.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      if (req_i[(int'(ptr_q) + k) % N_REQ]) begin
        win_vld = 1'b1;
        win_idx = IW'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == S_IDLE && win_vld)
      ptr_d = (win_idx == IW'(N_REQ-1)) ? '0 : win_idx + IW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      if (req_i[k]) begin
        win_vld = 1'b1;
        win_idx = IW'(k);
      end
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    data_d      = data_q;
    gap_d       = gap_q;
    rel_first_d = 1'b0;
    case (state_q)
      S_IDLE: if (win_vld) begin
        data_d  = reqData_i[{win_idx, 3'b000} +: 8];
        owner_d = win_idx;
        state_d = S_LOAD;
      end
      S_LOAD: state_d = S_SEND;
      S_SEND: if (charSent_i) begin
        state_d     = S_RELEASE;
        rel_first_d = 1'b1;
      end
      S_RELEASE: if (!charSent_i) begin
        state_d = S_GAP;
        gap_d   = 8'(GAP_CYCLES - 1);
      end
      S_GAP: begin
        if (gap_q == 8'd0) state_d = S_IDLE;
        else               gap_d   = gap_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the current state, so they trail the state by one clock.
  always_comb begin
    load_d  = (state_q == S_LOAD);
    te_d    = (state_q == S_LOAD) || (state_q == S_SEND);
    busy_d  = (state_q != S_IDLE);
    grant_d = '0;
    if (state_q == S_LOAD || state_q == S_SEND || state_q == S_RELEASE)
      grant_d = own_oh;
    done_d  = rel_first_q ? own_oh : '0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      owner_q     <= '0;
      data_q      <= 8'h00;
      gap_q       <= 8'h00;
      rel_first_q <= 1'b0;
      grant_q     <= '0;
      done_q      <= '0;
      busy_q      <= 1'b0;
      load_q      <= 1'b0;
      te_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      data_q      <= data_d;
      gap_q       <= gap_d;
      rel_first_q <= rel_first_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      load_q      <= load_d;
      te_q        <= te_d;
    end
  end

  assign grant_o          = grant_q;
  assign done_o           = done_q;
  assign busy_o           = busy_q;
  assign load_o           = load_q;
  assign transmitEnable_o = te_q;
  assign parallelDataIn_o = data_q;
endmodule
